// File: rtl/udiv_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package udiv_arb_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;

    // Result reported on a zero divisor or a hung divider.
    localparam logic [DIVIDEND_W-1:0] ERR_QUOTIENT  = 8'hFF;
    localparam logic [DIVISOR_W-1:0]  ERR_REMAINDER = 4'h0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/udiv_arbiter_rr_pick.sv
// Combinational round-robin selector. The scan starts at ptr, which is the
// highest-priority requester, and wraps modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    int               slot;
    logic [IDX_W-1:0] slot_idx;
    logic             found;

    // Walk the requesters in priority order and take the first one asserted.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that left
        // one unassigned would infer a latch.
        gnt      = '0;
        idx      = '0;
        found    = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            slot_idx = IDX_W'(slot);
            if (!found && req[slot_idx]) begin
                found         = 1'b1;
                gnt[slot_idx] = 1'b1;
                idx           = slot_idx;
            end
        end
    end

endmodule

// File: rtl/udiv_arbiter.sv
// Round-robin front end sharing one multi-cycle divider among NREQ requesters.
// One operation is in flight at a time; zero divisors are answered locally and
// a watchdog resets a divider that never raises done.
module udiv_arbiter
    import udiv_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                       CLK,
    input  logic                       iRESET,
    input  logic [NREQ-1:0]            iREQ,
    input  logic [NREQ*DIVIDEND_W-1:0] iDIVIDEND,
    input  logic [NREQ*DIVISOR_W-1:0]  iDIVISOR,
    output logic [NREQ-1:0]            oGNT,
    output logic [NREQ-1:0]            oRSPVLD,
    output logic [DIVIDEND_W-1:0]      oQUOTIENT,
    output logic [DIVISOR_W-1:0]       oREMAINDER,
    output logic                       oERR,
    output logic [DIVIDEND_W-1:0]      oDIV_DIVIDEND,
    output logic [DIVISOR_W-1:0]       oDIV_DIVISOR,
    output logic                       oDIV_VLD,
    output logic                       oDIV_RESET,
    input  logic [DIVIDEND_W-1:0]      iDIV_QUOTIENT,
    input  logic [DIVISOR_W-1:0]       iDIV_REMAINDER,
    input  logic                       iDIV_DONE
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int WDOG_W = 8;

    state_t                 state;
    state_t                 next_state;

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic [NREQ-1:0]        pick_gnt;
    logic [NREQ-1:0]        gnt_q;
    logic                   any_req;

    logic [DIVIDEND_W-1:0]  pick_dividend;
    logic [DIVISOR_W-1:0]   pick_divisor;
    logic [DIVIDEND_W-1:0]  op_dividend;
    logic [DIVISOR_W-1:0]   op_divisor;
    logic                   zero_div;

    logic [DIVIDEND_W-1:0]  res_quotient;
    logic [DIVISOR_W-1:0]   res_remainder;
    logic                   res_err;

    logic [WDOG_W-1:0]      wdog;
    logic                   wdog_expired;
    logic                   tmo_pulse;

    assign any_req      = |iREQ;
    assign wdog_expired = (wdog == WDOG_W'(TIMEOUT));
    assign next_ptr     = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (iREQ),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Route the winning requester's operands to the capture registers.
    always_comb begin
        pick_dividend = '0;
        pick_divisor  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_dividend = iDIVIDEND[k*DIVIDEND_W +: DIVIDEND_W];
                pick_divisor  = iDIVISOR[k*DIVISOR_W +: DIVISOR_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge iRESET) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge, independent of order.
        if (iRESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic. A zero-divisor operation still spends its grant
    // cycle in ISSUE, with the launch suppressed, so the error response lands
    // in the cycle right after the grant pulse.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   next_state = zero_div ? RESP : WAIT;
            WAIT:    if (iDIV_DONE || wdog_expired) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant, operand capture, result capture, watchdog and timeout pulse.
    always_ff @(posedge CLK or posedge iRESET) begin
        // NOTE: operand and result registers are reset too, so the divider
        // buses and the result buses read zero straight out of reset.
        if (iRESET) begin
            ptr           <= '0;
            owner         <= '0;
            gnt_q         <= '0;
            op_dividend   <= '0;
            op_divisor    <= '0;
            zero_div      <= 1'b0;
            res_quotient  <= '0;
            res_remainder <= '0;
            res_err       <= 1'b0;
            wdog          <= '0;
            tmo_pulse     <= 1'b0;
        end else begin
            gnt_q     <= '0;
            tmo_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ptr         <= next_ptr;
                        owner       <= pick_idx;
                        gnt_q       <= pick_gnt;
                        op_dividend <= pick_dividend;
                        op_divisor  <= pick_divisor;
                        zero_div    <= (pick_divisor == '0);
                    end
                end
                ISSUE: begin
                    wdog <= '0;
                    if (zero_div) begin
                        res_quotient  <= ERR_QUOTIENT;
                        res_remainder <= ERR_REMAINDER;
                        res_err       <= 1'b1;
                    end
                end
                WAIT: begin
                    // Done takes priority over a watchdog expiring on the same edge.
                    if (iDIV_DONE) begin
                        res_quotient  <= iDIV_QUOTIENT;
                        res_remainder <= iDIV_REMAINDER;
                        res_err       <= 1'b0;
                    end else if (wdog_expired) begin
                        res_quotient  <= ERR_QUOTIENT;
                        res_remainder <= ERR_REMAINDER;
                        res_err       <= 1'b1;
                        tmo_pulse     <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        oDIV_VLD   = (state == ISSUE) && !zero_div;
        oRSPVLD    = '0;
        oQUOTIENT  = '0;
        oREMAINDER = '0;
        oERR       = 1'b0;
        if (state == RESP) begin
            oRSPVLD[owner] = 1'b1;
            oQUOTIENT      = res_quotient;
            oREMAINDER     = res_remainder;
            oERR           = res_err;
        end
    end

    assign oGNT          = gnt_q;
    assign oDIV_DIVIDEND = op_dividend;
    assign oDIV_DIVISOR  = op_divisor;
    assign oDIV_RESET    = iRESET | tmo_pulse;

endmodule

// File: tb/tb_udiv_arbiter.sv
// Testbench for udiv_arbiter with a behavioural divider model.
module tb_udiv_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 31;
    localparam int LAT     = 3;

    logic                CLK = 1'b0;
    logic                iRESET;
    logic [NREQ-1:0]     iREQ;
    logic [NREQ*8-1:0]   iDIVIDEND;
    logic [NREQ*4-1:0]   iDIVISOR;
    logic [NREQ-1:0]     oGNT;
    logic [NREQ-1:0]     oRSPVLD;
    logic [7:0]          oQUOTIENT;
    logic [3:0]          oREMAINDER;
    logic                oERR;
    logic [7:0]          oDIV_DIVIDEND;
    logic [3:0]          oDIV_DIVISOR;
    logic                oDIV_VLD;
    logic                oDIV_RESET;
    logic [7:0]          iDIV_QUOTIENT;
    logic [3:0]          iDIV_REMAINDER;
    logic                iDIV_DONE;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    udiv_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK            (CLK),
        .iRESET         (iRESET),
        .iREQ           (iREQ),
        .iDIVIDEND      (iDIVIDEND),
        .iDIVISOR       (iDIVISOR),
        .oGNT           (oGNT),
        .oRSPVLD        (oRSPVLD),
        .oQUOTIENT      (oQUOTIENT),
        .oREMAINDER     (oREMAINDER),
        .oERR           (oERR),
        .oDIV_DIVIDEND  (oDIV_DIVIDEND),
        .oDIV_DIVISOR   (oDIV_DIVISOR),
        .oDIV_VLD       (oDIV_VLD),
        .oDIV_RESET     (oDIV_RESET),
        .iDIV_QUOTIENT  (iDIV_QUOTIENT),
        .iDIV_REMAINDER (iDIV_REMAINDER),
        .iDIV_DONE      (iDIV_DONE)
    );

    // Divider model: dividend taken on the launch edge, divisor one edge
    // later, done pulsed LAT edges after launch unless hung.
    logic       hung   = 1'b0;
    logic       m_done = 1'b0;
    logic [7:0] m_a    = '0;
    logic [3:0] m_b    = '0;
    logic [7:0] m_q    = '0;
    logic [3:0] m_r    = '0;
    int         m_cnt  = 0;
    logic       f_done = 1'b0;
    logic [7:0] f_q    = '0;
    logic [3:0] f_r    = '0;

    always @(posedge CLK) begin
        if (oDIV_RESET) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (oDIV_VLD) begin
            m_cnt  <= LAT;
            m_done <= 1'b0;
            m_a    <= oDIV_DIVIDEND;
        end else if (m_cnt != 0) begin
            m_cnt  <= m_cnt - 1;
            if (m_cnt == LAT) m_b <= oDIV_DIVISOR;
            m_done <= (m_cnt == 1) && !hung;
            if (m_cnt == 1 && m_b != 4'd0) begin
                m_q <= m_a / {4'b0, m_b};
                m_r <= 4'(m_a % {4'b0, m_b});
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    assign iDIV_DONE      = m_done | f_done;
    assign iDIV_QUOTIENT  = f_done ? f_q : m_q;
    assign iDIV_REMAINDER = f_done ? f_r : m_r;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       err;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_op(input int idx, input logic [7:0] a, input logic [3:0] b);
        for (int k = 0; k < NREQ; k++) begin
            if (k == idx) begin
                iDIVIDEND[k*8 +: 8] = a;
                iDIVISOR[k*4 +: 4]  = b;
            end
        end
    endtask

    task automatic wait_gnt();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            ok = (oGNT != '0);
        end
    endtask

    // One isolated request: grant, response, launch count and latency.
    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] oh;
        int  vld_n;
        int  cyc;
        bit  ok;
        oh = NREQ'(1) << v.idx;
        @(negedge CLK);
        set_op(v.idx, v.a, v.b);
        iREQ = oh;
        wait_gnt();
        check("vec_gnt", 32'(oGNT), 32'(oh));
        iREQ  = '0;
        vld_n = int'(oDIV_VLD);
        cyc   = 0;
        ok    = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            cyc++;
            if (oDIV_VLD) vld_n++;
            ok = (oRSPVLD != '0);
        end
        check("vec_rspvld", 32'(oRSPVLD), 32'(oh));
        check("vec_quotient", 32'(oQUOTIENT), 32'(v.q));
        check("vec_remainder", 32'(oREMAINDER), 32'(v.r));
        check("vec_err", 32'(oERR), 32'(v.err));
        check("vec_vld_pulses", 32'(vld_n), (v.b != 4'd0) ? 32'd1 : 32'd0);
        check("vec_latency", 32'(cyc), (v.b != 4'd0) ? 32'(LAT + 2) : 32'd1);
        @(negedge CLK);
        check("vec_rspvld_one_cycle", 32'(oRSPVLD), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] exp_oh;
        int  cyc;
        bit  ok;
        bit  seen;

        vecs[0] = '{1, 8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        vecs[1] = '{2, 8'd99,  4'd0,  8'hFF,  4'd0, 1'b1};
        vecs[2] = '{0, 8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        vecs[3] = '{3, 8'd13,  4'd5,  8'd2,   4'd3, 1'b0};
        vecs[4] = '{1, 8'd7,   4'd9,  8'd0,   4'd7, 1'b0};
        vecs[5] = '{3, 8'd0,   4'd0,  8'hFF,  4'd0, 1'b1};
        vecs[6] = '{2, 8'd255, 4'd1,  8'd255, 4'd0, 1'b0};

        // Asynchronous reset, observed before any clock edge.
        iRESET    = 1'b0;
        iREQ      = '0;
        iDIVIDEND = '0;
        iDIVISOR  = '0;
        #1 iRESET = 1'b1;
        #1;
        check("rst_gnt", 32'(oGNT), 32'd0);
        check("rst_rspvld", 32'(oRSPVLD), 32'd0);
        check("rst_quotient", 32'(oQUOTIENT), 32'd0);
        check("rst_err", 32'(oERR), 32'd0);
        check("rst_div_vld", 32'(oDIV_VLD), 32'd0);
        check("rst_div_dividend", 32'(oDIV_DIVIDEND), 32'd0);
        check("rst_div_reset", 32'(oDIV_RESET), 32'd1);
        repeat (3) @(negedge CLK);
        iRESET = 1'b0;
        #1;
        check("rst_div_reset_released", 32'(oDIV_RESET), 32'd0);

        // All four requesting continuously: grants rotate 0,1,2,3,0.
        @(negedge CLK);
        for (int k = 0; k < NREQ; k++) set_op(k, 8'd255, 4'd15);
        iREQ = '1;
        for (int k = 0; k < 5; k++) begin
            exp_oh = NREQ'(1) << (k % NREQ);
            wait_gnt();
            check("rr_gnt", 32'(oGNT), 32'(exp_oh));
            ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge CLK);
                ok = (oRSPVLD != '0);
            end
            check("rr_rspvld", 32'(oRSPVLD), 32'(exp_oh));
            check("rr_quotient", 32'(oQUOTIENT), 32'd17);
            check("rr_remainder", 32'(oREMAINDER), 32'd0);
        end
        iREQ = '0;

        // Table of isolated single requests, including zero divisors.
        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Hung divider: watchdog reset pulse and error response.
        hung = 1'b1;
        @(negedge CLK);
        set_op(1, 8'd50, 4'd5);
        iREQ = 4'b0010;
        wait_gnt();
        check("hung_gnt", 32'(oGNT), 32'h2);
        iREQ = '0;
        cyc  = 0;
        ok   = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 5) begin
                check("hung_hold_dividend", 32'(oDIV_DIVIDEND), 32'd50);
                check("hung_hold_divisor", 32'(oDIV_DIVISOR), 32'd5);
            end
            ok = oDIV_RESET;
        end
        check("hung_reset_delay", 32'(cyc), 32'(TIMEOUT + 2));
        check("hung_rspvld", 32'(oRSPVLD), 32'h2);
        check("hung_err", 32'(oERR), 32'd1);
        check("hung_quotient", 32'(oQUOTIENT), 32'hFF);
        check("hung_remainder", 32'(oREMAINDER), 32'd0);
        @(negedge CLK);
        check("hung_reset_one_cycle", 32'(oDIV_RESET), 32'd0);
        hung = 1'b0;
        run_vec('{1, 8'd50, 4'd5, 8'd10, 4'd0, 1'b0});

        // Done arriving on the watchdog-expiry edge wins.
        hung = 1'b1;
        @(negedge CLK);
        set_op(0, 8'd100, 4'd3);
        iREQ = 4'b0001;
        wait_gnt();
        check("race_gnt", 32'(oGNT), 32'h1);
        iREQ = '0;
        for (int i = 0; i < TIMEOUT + 1; i++) @(negedge CLK);
        f_q    = 8'hAB;
        f_r    = 4'h5;
        f_done = 1'b1;
        @(negedge CLK);
        f_done = 1'b0;
        check("race_rspvld", 32'(oRSPVLD), 32'h1);
        check("race_quotient", 32'(oQUOTIENT), 32'hAB);
        check("race_remainder", 32'(oREMAINDER), 32'h5);
        check("race_err", 32'(oERR), 32'd0);
        check("race_no_div_reset", 32'(oDIV_RESET), 32'd0);
        hung = 1'b0;

        // Asynchronous reset in WAIT aborts the operation silently.
        @(negedge CLK);
        set_op(2, 8'd60, 4'd6);
        iREQ = 4'b0100;
        wait_gnt();
        check("abort_gnt", 32'(oGNT), 32'h4);
        iREQ = '0;
        @(negedge CLK);
        #2 iRESET = 1'b1;
        #1;
        check("abort_rspvld", 32'(oRSPVLD), 32'd0);
        check("abort_quotient", 32'(oQUOTIENT), 32'd0);
        check("abort_div_vld", 32'(oDIV_VLD), 32'd0);
        check("abort_div_dividend", 32'(oDIV_DIVIDEND), 32'd0);
        check("abort_div_divisor", 32'(oDIV_DIVISOR), 32'd0);
        check("abort_div_reset", 32'(oDIV_RESET), 32'd1);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        iRESET = 1'b0;
        seen   = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (oRSPVLD != '0) seen = 1'b1;
        end
        check("abort_no_response", 32'(seen), 32'd0);

        // Pointer is back at requester 0 after reset.
        for (int k = 0; k < NREQ; k++) set_op(k, 8'd255, 4'd15);
        iREQ = '1;
        wait_gnt();
        check("post_reset_gnt", 32'(oGNT), 32'h1);
        iREQ = '0;
        ok   = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            ok = (oRSPVLD != '0);
        end
        check("post_reset_rspvld", 32'(oRSPVLD), 32'h1);
        check("post_reset_quotient", 32'(oQUOTIENT), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
